// File: rtl/parity_stop_check_rx.sv
// UART RX parity/stop checker: serial parity accumulation, four parity modes,
// stop-bit and strobe-sequence checking, plus sticky flags and saturating error counters.

module parity_stop_err_stat #(
  parameter int CNT_WIDTH = 8
) (
  input  logic                 CLK_par,
  input  logic                 RST_par,
  input  logic                 evt,
  input  logic                 clr,
  output logic                 sticky,
  output logic [CNT_WIDTH-1:0] cnt
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  // evt is the next-state of the pulse, so the count moves on the same edge the pulse rises.
  // An event coinciding with a clear survives as a fresh count of 1.
  always_ff @(posedge CLK_par or negedge RST_par) begin
    if (!RST_par) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end else if (evt) begin
      sticky <= 1'b1;
      if (clr)                 cnt <= CNT_WIDTH'(1);
      else if (cnt != CNT_MAX) cnt <= cnt + CNT_WIDTH'(1);
    end else if (clr) begin
      sticky <= 1'b0;
      cnt    <= '0;
    end
  end
endmodule

module parity_stop_check_rx #(
  parameter int DATA_LENGTH = 8,
  parameter int CNT_WIDTH   = 8
) (
  input  logic                 CLK_par,
  input  logic                 RST_par,
  input  logic                 start_frame,
  input  logic                 PAR_EN,
  input  logic [1:0]           PAR_TYP,
  input  logic                 sampled_bit,
  input  logic                 data_bit_valid,
  input  logic                 par_chk_en,
  input  logic                 stp_chk_en,
  input  logic                 err_clr,
  output logic                 par_err,
  output logic                 stp_err,
  output logic                 seq_err,
  output logic                 frame_done,
  output logic                 par_err_sticky,
  output logic                 stp_err_sticky,
  output logic [CNT_WIDTH-1:0] par_err_cnt,
  output logic [CNT_WIDTH-1:0] stp_err_cnt
);
  localparam int              BW   = $clog2(DATA_LENGTH + 1);
  localparam logic [BW-1:0]   LAST = BW'(DATA_LENGTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

  state_t        state;
  logic          acc;
  logic [BW-1:0] bit_cnt;
  logic          par_en_q;
  logic [1:0]    par_typ_q;

  logic exp_par, multi, any_strb;
  logic act_dv, act_pc, act_sc;
  logic par_nxt, stp_nxt, seq_nxt, done_nxt;

  always_comb begin
    case (par_typ_q)
      2'b00:   exp_par = acc;
      2'b01:   exp_par = ~acc;
      2'b10:   exp_par = 1'b1;
      default: exp_par = 1'b0;
    endcase
  end

  assign multi    = (data_bit_valid & par_chk_en) | (data_bit_valid & stp_chk_en) |
                    (par_chk_en & stp_chk_en);
  assign any_strb = data_bit_valid | par_chk_en | stp_chk_en;

  // start_frame masks every strobe; a lone strobe is acted on only in its own state.
  assign act_dv = !start_frame && !multi && data_bit_valid && state == DATA;
  assign act_pc = !start_frame && !multi && par_chk_en     && state == PARITY;
  assign act_sc = !start_frame && !multi && stp_chk_en     && state == STOP;

  assign seq_nxt  = !start_frame && any_strb && !(act_dv || act_pc || act_sc);
  assign par_nxt  = act_pc && (sampled_bit != exp_par);
  assign stp_nxt  = act_sc && !sampled_bit;
  assign done_nxt = act_sc;

  always_ff @(posedge CLK_par or negedge RST_par) begin
    if (!RST_par) begin
      state      <= IDLE;
      acc        <= 1'b0;
      bit_cnt    <= '0;
      par_en_q   <= 1'b1;
      par_typ_q  <= 2'b00;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      seq_err    <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      par_err    <= par_nxt;
      stp_err    <= stp_nxt;
      seq_err    <= seq_nxt;
      frame_done <= done_nxt;
      if (start_frame) begin
        state     <= DATA;
        acc       <= 1'b0;
        bit_cnt   <= '0;
        par_en_q  <= PAR_EN;
        par_typ_q <= PAR_TYP;
      end else if (act_dv) begin
        acc     <= acc ^ sampled_bit;
        bit_cnt <= bit_cnt + BW'(1);
        if (bit_cnt + BW'(1) == LAST) state <= par_en_q ? PARITY : STOP;
      end else if (act_pc) begin
        state <= STOP;
      end else if (act_sc) begin
        state <= IDLE;
      end
    end
  end

  parity_stop_err_stat #(.CNT_WIDTH(CNT_WIDTH)) u_par_stat (
    .CLK_par(CLK_par), .RST_par(RST_par), .evt(par_nxt), .clr(err_clr),
    .sticky(par_err_sticky), .cnt(par_err_cnt)
  );

  parity_stop_err_stat #(.CNT_WIDTH(CNT_WIDTH)) u_stp_stat (
    .CLK_par(CLK_par), .RST_par(RST_par), .evt(stp_nxt), .clr(err_clr),
    .sticky(stp_err_sticky), .cnt(stp_err_cnt)
  );
endmodule

// File: tb/tb_parity_stop_check_rx.sv
// Directed bench for parity_stop_check_rx: default, 2-bit-counter and 5-bit-frame
// instances share one stimulus stream.
module tb_parity_stop_check_rx;
  logic CLK_par = 1'b0;
  logic RST_par = 1'b0;
  logic start_frame, PAR_EN, sampled_bit, data_bit_valid, par_chk_en, stp_chk_en, err_clr;
  logic [1:0] PAR_TYP;

  logic a_par_err, a_stp_err, a_seq_err, a_frame_done, a_par_sticky, a_stp_sticky;
  logic [7:0] a_par_cnt, a_stp_cnt;
  logic c_par_err, c_stp_err, c_seq_err, c_frame_done, c_par_sticky, c_stp_sticky;
  logic [1:0] c_par_cnt, c_stp_cnt;
  logic l_par_err, l_stp_err, l_seq_err, l_frame_done, l_par_sticky, l_stp_sticky;
  logic [7:0] l_par_cnt, l_stp_cnt;

  int npass = 0, ntot = 0, nfail = 0;

  parity_stop_check_rx #(.DATA_LENGTH(8), .CNT_WIDTH(8)) dut_a (
    .CLK_par(CLK_par), .RST_par(RST_par), .start_frame(start_frame), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .data_bit_valid(data_bit_valid),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .err_clr(err_clr),
    .par_err(a_par_err), .stp_err(a_stp_err), .seq_err(a_seq_err), .frame_done(a_frame_done),
    .par_err_sticky(a_par_sticky), .stp_err_sticky(a_stp_sticky),
    .par_err_cnt(a_par_cnt), .stp_err_cnt(a_stp_cnt));

  parity_stop_check_rx #(.DATA_LENGTH(8), .CNT_WIDTH(2)) dut_c (
    .CLK_par(CLK_par), .RST_par(RST_par), .start_frame(start_frame), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .data_bit_valid(data_bit_valid),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .err_clr(err_clr),
    .par_err(c_par_err), .stp_err(c_stp_err), .seq_err(c_seq_err), .frame_done(c_frame_done),
    .par_err_sticky(c_par_sticky), .stp_err_sticky(c_stp_sticky),
    .par_err_cnt(c_par_cnt), .stp_err_cnt(c_stp_cnt));

  parity_stop_check_rx #(.DATA_LENGTH(5), .CNT_WIDTH(8)) dut_l (
    .CLK_par(CLK_par), .RST_par(RST_par), .start_frame(start_frame), .PAR_EN(PAR_EN),
    .PAR_TYP(PAR_TYP), .sampled_bit(sampled_bit), .data_bit_valid(data_bit_valid),
    .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .err_clr(err_clr),
    .par_err(l_par_err), .stp_err(l_stp_err), .seq_err(l_seq_err), .frame_done(l_frame_done),
    .par_err_sticky(l_par_sticky), .stp_err_sticky(l_stp_sticky),
    .par_err_cnt(l_par_cnt), .stp_err_cnt(l_stp_cnt));

  logic [3:0] a_pul, l_pul;
  assign a_pul = {a_par_err, a_stp_err, a_seq_err, a_frame_done};
  assign l_pul = {l_par_err, l_stp_err, l_seq_err, l_frame_done};

  always #5 CLK_par = ~CLK_par;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge CLK_par); #1;
  endtask

  task automatic clr_in;
    start_frame = 0; data_bit_valid = 0; par_chk_en = 0; stp_chk_en = 0;
    err_clr = 0; sampled_bit = 0;
  endtask

  task automatic start(input logic en, input logic [1:0] typ);
    PAR_EN = en; PAR_TYP = typ; start_frame = 1; tick; clr_in;
  endtask

  task automatic bits(input logic [15:0] d, input int n);
    for (int i = 0; i < n; i++) begin
      data_bit_valid = 1; sampled_bit = d[i]; tick; clr_in;
    end
  endtask

  task automatic par(input logic b);
    par_chk_en = 1; sampled_bit = b; tick; clr_in;
  endtask

  task automatic stop(input logic b);
    stp_chk_en = 1; sampled_bit = b; tick; clr_in;
  endtask

  initial begin
    clr_in; PAR_EN = 0; PAR_TYP = 2'b00;
    #3;
    chk("rst_pulses", a_pul, 0);
    chk("rst_stat", {a_par_sticky, a_stp_sticky, a_par_cnt, a_stp_cnt}, 0);
    #9 RST_par = 1;

    // even, 0xA5 (four ones) -> parity 0 is correct
    start(1, 2'b00); chk("t1_start", a_pul, 0);
    bits(16'hA5, 8);  chk("t1_bits", a_pul, 0);
    par(0);           chk("t1_par", a_pul, 0);
    stop(1);          chk("t1_stop", a_pul, 4'b0001);
    tick;             chk("t1_done_1cyc", a_pul, 0);

    // odd, 0xA5 -> parity 0 wrong, 1 right
    start(1, 2'b01); bits(16'hA5, 8); par(0);
    chk("t2_par_err", a_pul, 4'b1000);
    chk("t2_stat", {a_par_sticky, a_par_cnt}, {1'b1, 8'd1});
    stop(1); chk("t2_stop", a_pul, 4'b0001);
    start(1, 2'b01); bits(16'hA5, 8); par(1);
    chk("t2b_par_ok", a_pul, 0);
    chk("t2b_cnt", a_par_cnt, 1);
    stop(1);

    // mark / space with zero data, then no-parity frame with bad stop
    start(1, 2'b10); bits(16'h00, 8); par(0); chk("mark_err", a_pul, 4'b1000); stop(1);
    start(1, 2'b11); bits(16'h00, 8); par(0); chk("space_ok", a_pul, 0); stop(1);
    start(0, 2'b00); bits(16'h00, 8); stop(0);
    chk("nopar_stp_err", a_pul, 4'b0101);
    chk("stp_stat", {a_stp_sticky, a_stp_cnt, a_par_cnt}, {1'b1, 8'd1, 8'd2});

    // out-of-sequence strobes
    par(0); chk("seq_idle", a_pul, 4'b0010);
    start(1, 2'b00); bits(16'hA5, 3);
    stop(1); chk("seq_data", a_pul, 4'b0010);
    bits(16'h14, 5);
    par(0); chk("seq_resume_par", a_pul, 0);
    stop(1); chk("seq_resume_stop", a_pul, 4'b0001);

    // two strobes at once are rejected and ignored
    start(1, 2'b00); bits(16'hA5, 2);
    data_bit_valid = 1; par_chk_en = 1; sampled_bit = 1; tick; clr_in;
    chk("multi_strobe", a_pul, 4'b0010);
    bits(16'h29, 6); par(0); chk("multi_par", a_pul, 0);
    stop(1); chk("multi_stop", a_pul, 4'b0001);

    // restart mid-frame with a strobe, then mode pins change mid-frame
    start(1, 2'b00); bits(16'h1F, 5);
    PAR_EN = 1; PAR_TYP = 2'b00; start_frame = 1; data_bit_valid = 1; tick; clr_in;
    chk("restart_no_seq", a_pul, 0);
    PAR_EN = 0; PAR_TYP = 2'b01;
    bits(16'hA5, 8); par(0); chk("restart_par", a_pul, 0);
    stop(1); chk("restart_stop", a_pul, 4'b0001);

    // clear, saturation, clear-with-event, clear alone
    err_clr = 1; tick; clr_in;
    chk("clr_all", {a_par_sticky, a_stp_sticky, a_par_cnt, a_stp_cnt, c_par_sticky, c_par_cnt}, 0);
    for (int k = 0; k < 5; k++) begin
      start(1, 2'b10); bits(16'h00, 8); par(0); stop(1);
    end
    chk("sat_c", {c_par_sticky, c_par_cnt}, {1'b1, 2'd3});
    chk("cnt_a5", a_par_cnt, 5);
    start(1, 2'b10); bits(16'h00, 8); err_clr = 1; par(0);
    chk("clr_evt_pulse", a_pul, 4'b1000);
    chk("clr_evt_c", {c_par_sticky, c_par_cnt}, {1'b1, 2'd1});
    chk("clr_evt_a", a_par_cnt, 1);
    stop(1);
    err_clr = 1; tick; clr_in;
    chk("clr_alone", {c_par_sticky, c_par_cnt, a_par_sticky, a_par_cnt}, 0);

    // 5-bit instance: error, async reset in PARITY, clean frame
    RST_par = 0; #3 RST_par = 1;
    start(1, 2'b00); bits(16'h16, 5); par(0);
    chk("l_par_err", {l_pul, l_par_sticky, l_par_cnt}, {4'b1000, 1'b1, 8'd1});
    stop(1); chk("l_stop", l_pul, 4'b0001);
    start(1, 2'b00); bits(16'h16, 5);
    #2 RST_par = 0;
    #1 chk("l_async_rst", {l_pul, l_par_sticky, l_stp_sticky, l_par_cnt, l_stp_cnt}, 0);
    #1 RST_par = 1;
    start(1, 2'b00); bits(16'h16, 5); par(1);
    chk("l_par_ok", l_pul, 0);
    stop(1); chk("l_stop_ok", l_pul, 4'b0001);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule

// File: doc/parity_stop_check_rx.md
Name: parity_stop_check_rx

Overview:
Parametrised successor to the UART RX parity checker. Accumulates parity serially as data bits are sampled and checks the parity bit in one of four modes: even, odd, mark or space. Also checks the stop bit and flags strobes that arrive out of sequence. Keeps sticky error flags and saturating error counters for the status block. Sits between the RX bit sampler/FSM and the RX status/output stage.

Parameters:
DATA_LENGTH, 8, data bits per frame (1..16)
CNT_WIDTH, 8, width of each saturating error counter

Ports:
CLK_par  in  1  clock; all state on rising edge
RST_par  in  1  reset, asynchronous, active-low
start_frame  in  1  pulse on start-bit detect; clears accumulator, latches mode
PAR_EN  in  1  parity bit present (latched at start_frame)
PAR_TYP  in  2  00 even, 01 odd, 10 mark, 11 space (latched at start_frame)
sampled_bit  in  1  current sampled bit value
data_bit_valid  in  1  strobe: sampled_bit is a data bit
par_chk_en  in  1  strobe: sampled_bit is the parity bit
stp_chk_en  in  1  strobe: sampled_bit is the stop bit
err_clr  in  1  clears sticky flags and counters
par_err  out  1  one-cycle pulse on parity mismatch
stp_err  out  1  one-cycle pulse when stop bit is 0
seq_err  out  1  one-cycle pulse on an out-of-sequence strobe
frame_done  out  1  one-cycle pulse after the stop bit is checked
par_err_sticky  out  1  set by par_err, cleared by err_clr
stp_err_sticky  out  1  set by stp_err, cleared by err_clr
par_err_cnt  out  CNT_WIDTH  saturating parity-error count
stp_err_cnt  out  CNT_WIDTH  saturating stop-error count

Behaviour:
- Reset:
  - All outputs 0.
  - State IDLE; accumulator 0; bit counter 0; latched mode 00 with parity enabled.
- FSM states: IDLE, DATA, PARITY, STOP. Bit counter is $clog2(DATA_LENGTH+1) bits wide.
- start_frame:
  - Highest priority; valid in any state.
  - Effect: accumulator 0, bit counter 0, PAR_EN/PAR_TYP latched, state goes to DATA.
  - Other strobes in the same cycle are ignored with no seq_err.
  - A frame in progress is silently abandoned, with no error pulses.
- DATA, on data_bit_valid:
  - accumulator ^= sampled_bit; counter++.
  - On the strobe that makes the counter equal DATA_LENGTH: go to PARITY if latched PAR_EN=1, else to STOP.
- PARITY, on par_chk_en:
  - Expected bit: even = accumulator, odd = ~accumulator, mark = 1, space = 0.
  - par_err pulses in the next cycle if sampled_bit differs from expected.
  - Go to STOP.
- STOP, on stp_chk_en:
  - stp_err pulses in the next cycle if sampled_bit = 0.
  - frame_done pulses in the same next cycle.
  - Go to IDLE.
- Out-of-sequence strobes:
  - Any of data_bit_valid, par_chk_en or stp_chk_en asserted outside its own state (including IDLE) gives a seq_err pulse in the next cycle.
  - State and accumulator are unchanged.
  - Two or more of these strobes in one cycle: seq_err pulses and none of them is acted on.
- Latency: every pulse output is registered and asserts exactly 1 cycle after its strobe, for 1 cycle.
- Sticky flags and counters:
  - Each counter increments by 1 on the cycle its pulse output asserts. It saturates at 2^CNT_WIDTH-1 with no wrap.
  - err_clr in a cycle with no pulse: sticky flag 0, counter 0.
  - err_clr in the same cycle as a pulse: sticky flag 1, counter 1. The event is kept.
- Mode changes on PAR_EN/PAR_TYP mid-frame have no effect until the next start_frame.
- Asynchronous reset mid-frame returns the block to the reset state immediately. No pulse is emitted.

Test Plan:
- Even mode, 8 bits, data 0xA5 LSB first, parity bit 0, stop 1 -> par_err 0, stp_err 0, frame_done pulses 1 cycle after stp_chk_en.
- Odd mode, data 0xA5, parity bit 0 -> par_err pulses once, par_err_sticky=1, par_err_cnt=1. Repeat with parity bit 1 -> no error.
- Mark and space modes, data 0x00, parity bit 0 -> mark gives par_err, space does not. PAR_EN=0, stop 0 -> STOP is reached directly after 8 bits and stp_err pulses.
- par_chk_en in IDLE, and stp_chk_en during DATA after 3 bits -> seq_err pulses each time, bit count continues from 3. start_frame after 5 bits -> next frame checks cleanly.
- CNT_WIDTH=2, five parity errors -> par_err_cnt saturates at 3. err_clr together with a 6th error -> count 1, sticky 1. err_clr alone -> count 0, sticky 0.
- DATA_LENGTH=5, reset asserted during PARITY -> all outputs 0 at once. Next frame 5'b10110, even parity bit 1 -> no error.
